reg_mem_2r1w: RTL and testbench
===============================

REG_MEM_2R1W -- requirements
Module: reg_mem_2r1w

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word and of all data ports.
REQ-002 Parameter ADDR_BITS, default 5: address width; DEPTH = 2**ADDR_BITS words (default 32).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wen  input  1  write enable.
REQ-006 waddr  input  ADDR_BITS  write address.
REQ-007 wdata  input  DATA_WIDTH  write data.
REQ-008 raddr_a  input  ADDR_BITS  read port A address.
REQ-009 raddr_b  input  ADDR_BITS  read port B address.
REQ-010 clr  input  1  single-cycle request to zero the whole memory.
REQ-011 rdata_a  output  DATA_WIDTH  registered read data, port A.
REQ-012 rdata_b  output  DATA_WIDTH  registered read data, port B.
REQ-013 busy  output  1  high while the clear sweep runs; writes ignored.

Function
REQ-014 Storage SHALL be DEPTH x DATA_WIDTH registers; one write port, two independent read ports.
REQ-015 Read latency SHALL be 1 cycle: rdata_x after edge N = mem[raddr_x sampled at edge N].
REQ-016 Both read ports SHALL accept any address, including the same address, in the same cycle.
REQ-017 In IDLE, wen=1 at an edge SHALL write wdata to mem[waddr]; written value readable from the following edge.
REQ-018 FSM states: IDLE (busy=0), CLEAR (busy=1); busy SHALL be decoded directly from state.
REQ-019 IDLE -> CLEAR when clr=1 at an edge; clear pointer loaded with 0.
REQ-020 In CLEAR, each edge SHALL write 0 to mem[ptr] and increment ptr (ADDR_BITS wide, wraps).
REQ-021 CLEAR -> IDLE on the edge that clears address DEPTH-1; busy high for exactly DEPTH cycles.
REQ-022 clr=1 in CLEAR SHALL be ignored (no restart, no extension).
REQ-023 wen=1 in CLEAR SHALL be dropped; no storage change beyond the sweep.
REQ-024 wen=1 and clr=1 together in IDLE: clr wins, write dropped, sweep starts.
REQ-025 While busy=1, rdata_a and rdata_b SHALL be registered as 0 regardless of address.
REQ-026 Addresses are unsigned ADDR_BITS values; no out-of-range case exists.

Reset
REQ-027 rst=1 at an edge SHALL set rdata_a=0, rdata_b=0, state=CLEAR, ptr=0, so busy=1 after that edge.
REQ-028 After rst deasserts, the sweep SHALL run DEPTH cycles and return to IDLE; memory is zero afterwards.
REQ-029 rst during a sweep SHALL restart it from address 0; rst overrides wen, clr and all reads.
REQ-030 Memory contents SHALL NOT be reset directly by rst; zeroing is done only by the sweep.

Configuration
REQ-031 Macro REG_MEM_BYPASS_EN selects write-to-read forwarding.
REQ-032 Defined: in IDLE, if wen=1 and raddr_x==waddr at an edge, rdata_x SHALL take wdata (new data).
REQ-033 Undefined: same case, rdata_x SHALL take the old mem[raddr_x] (read-before-write).
REQ-034 Forwarding SHALL never apply while busy=1 or when clr wins (REQ-024).

Verification (DATA_WIDTH=8, ADDR_BITS=5)
REQ-035 rst high 2 cycles then low -> busy high exactly 32 cycles after release, then low; reads of addr 0..31 return 0.
REQ-036 Write i to address i-10 for i=10..41, then read A=addr k, B=addr 31-k for k=0..31 -> rdata_a=k+10, rdata_b=41-k one cycle later.
REQ-037 mem[5]=0x33; wen=1, waddr=5, wdata=0xA5, raddr_a=5 same edge -> rdata_a=0xA5 with REG_MEM_BYPASS_EN, 0x33 without; next cycle 0xA5 both builds.
REQ-038 Memory filled non-zero, clr pulse with wen=1 waddr=3 wdata=0x77 -> busy high 32 cycles, rdata 0 while busy, mem[3]=0 afterwards; second clr at sweep cycle 10 does not extend busy.
REQ-039 wen=1 writing 0xFF to addr 20 during sweep cycle 5 -> addr 20 reads 0 after sweep.
REQ-040 rst asserted at sweep cycle 17 -> busy stays high, sweep restarts; busy falls exactly 32 cycles after rst release.

Source files
------------

// File: rtl/reg_mem_2r1w.sv
// reg_mem_2r1w: DEPTH x DATA_WIDTH register memory, one write port, two
// registered read ports (1-cycle latency) and a self-timed clear sweep.
//
// Optional feature macro: REG_MEM_BYPASS_EN
//   defined   -> a same-edge write to the address being read is forwarded
//                to that read port (new data).
//   undefined -> read-before-write: the read port returns the old word.
//
// Control protocol: there is no valid/ready handshake. A write is accepted
// on any rising edge where wen=1 while busy=0 and clr=0. A clear request is
// accepted on any rising edge where clr=1 while busy=0; clr wins over wen.
// While busy=1, wen and clr are dropped and both read ports return 0.
module reg_mem_2r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr_a,
  input  logic [ADDR_BITS-1:0]  raddr_b,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_BITS-1:0]   ptr_q;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic                   user_write;
  logic                   fwd_a;
  logic                   fwd_b;

  // A user write is only taken in IDLE and only when no clear is requested.
  assign user_write = (state_q == IDLE) && wen && !clr;

`ifdef REG_MEM_BYPASS_EN
  assign fwd_a = user_write && (raddr_a == waddr);
  assign fwd_b = user_write && (raddr_b == waddr);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // State register: reset forces a fresh sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start sweep on clr; leave after clearing the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr) state_d = CLEAR;
      CLEAR:   if (ptr_q == '1) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state_q == CLEAR);
  end

  // Sweep pointer: loaded with 0 on entry, advances once per sweep edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state_q == IDLE) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_q + ADDR_BITS'(1);
    end
  end

  // Single memory write port shared by the sweep and the user.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
      end else if (user_write) begin
        mem_we    = 1'b1;
      end
    end
  end

  // Storage array; contents are zeroed only by the sweep, never by rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read ports: zero under reset or sweep, optional forwarding.
  always_ff @(posedge clk) begin
    if (rst || state_q == CLEAR) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= fwd_a ? wdata : mem[raddr_a];
      rdata_b <= fwd_b ? wdata : mem[raddr_b];
    end
  end

endmodule

// File: tb/tb_reg_mem_2r1w.sv
// Directed testbench for reg_mem_2r1w (DATA_WIDTH=8, ADDR_BITS=5).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_reg_mem_2r1w;

  localparam int DW = 8;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic          clr;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          busy;

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  reg_mem_2r1w #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .clr     (clr),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .busy    (busy)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wen = 1'b0; clr = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  // Counts busy-high samples until busy falls (bounded), compares to want.
  task automatic count_busy(input string name, input int want);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (!busy) break;
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== want) begin
      n_fail++;
      $display("FAIL %s: busy cycles got %0d want %0d", name, cnt, want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int cnt;
    rst = 1'b1; idle_inputs(); raddr_a = 0; raddr_b = 0;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b1 || rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b a=%h b=%h want 1/00/00", busy, rdata_a, rdata_b);
    end
    rst = 1'b0;
    // busy sampled now already counts as the first post-release cycle
    tick();
    cnt = 1;
    for (int i = 0; i < 64; i++) begin
      if (!busy) break;
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 32) begin
      n_fail++;
      $display("FAIL reset_busy_len: got %0d want 32", cnt);
    end
    for (int k = 0; k < 32; k++) begin
      raddr_a = AW'(k); raddr_b = AW'(31 - k);
      tick();
      n_cmp++;
      if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_zero[%0d]: a=%h b=%h want 00", k, rdata_a, rdata_b);
      end
    end
  endtask

  task automatic test_fill_read();
    for (int i = 10; i <= 41; i++) write_word(AW'(i - 10), DW'(i));
    for (int k = 0; k < 32; k++) begin
      raddr_a = AW'(k); raddr_b = AW'(31 - k);
      tick();
      n_cmp++;
      if (rdata_a !== DW'(k + 10) || rdata_b !== DW'(41 - k)) begin
        n_fail++;
        $display("FAIL fill_read[%0d]: a=%h want %h b=%h want %h",
                 k, rdata_a, DW'(k + 10), rdata_b, DW'(41 - k));
      end
    end
    raddr_a = 7; raddr_b = 7;
    tick();
    n_cmp++;
    if (rdata_a !== 8'd17 || rdata_b !== 8'd17) begin
      n_fail++;
      $display("FAIL same_addr: a=%h b=%h want 11", rdata_a, rdata_b);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_a;
`ifdef REG_MEM_BYPASS_EN
    exp_a = 8'hA5;
`else
    exp_a = 8'h33;
`endif
    write_word(5, 8'h33);
    wen = 1'b1; waddr = 5; wdata = 8'hA5; raddr_a = 5; raddr_b = 6;
    tick();
    wen = 1'b0;
    n_cmp++;
    if (rdata_a !== exp_a || rdata_b !== 8'd16) begin
      n_fail++;
      $display("FAIL bypass_same_edge: a=%h want %h b=%h want 10", rdata_a, exp_a, rdata_b);
    end
    tick();
    n_cmp++;
    if (rdata_a !== 8'hA5) begin
      n_fail++;
      $display("FAIL bypass_next: a=%h want a5", rdata_a);
    end
  endtask

  task automatic test_clear();
    int cnt;
    int zero_bad;
    // clr and wen together: clr wins, no forwarding, old mem[3]=13 read
    clr = 1'b1; wen = 1'b1; waddr = 3; wdata = 8'h77; raddr_a = 3; raddr_b = 31;
    tick();
    clr = 1'b0; wen = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || rdata_a !== 8'd13 || rdata_b !== 8'd41) begin
      n_fail++;
      $display("FAIL clr_start: busy=%b a=%h want 0d b=%h want 29", busy, rdata_a, rdata_b);
    end
    cnt = 1; zero_bad = 0;
    for (int i = 1; i < 64; i++) begin
      clr = (i == 10);
      tick();
      clr = 1'b0;
      if (rdata_a !== 8'h00 || rdata_b !== 8'h00) zero_bad++;
      if (!busy) break;
      cnt++;
    end
    n_cmp++;
    if (cnt !== 32) begin
      n_fail++;
      $display("FAIL clr_busy_len: got %0d want 32", cnt);
    end
    n_cmp++;
    if (zero_bad !== 0) begin
      n_fail++;
      $display("FAIL clr_rdata_zero: %0d nonzero samples want 0", zero_bad);
    end
    raddr_a = 3; raddr_b = 31;
    tick();
    n_cmp++;
    if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_after: a=%h b=%h want 00", rdata_a, rdata_b);
    end
    write_word(9, 8'h42);
    raddr_a = 9;
    tick();
    n_cmp++;
    if (rdata_a !== 8'h42) begin
      n_fail++;
      $display("FAIL write_after_clr: a=%h want 42", rdata_a);
    end
  endtask

  task automatic test_write_during_sweep();
    write_word(20, 8'h5A);
    raddr_a = 20;
    tick();
    n_cmp++;
    if (rdata_a !== 8'h5A) begin
      n_fail++;
      $display("FAIL pre_sweep_20: a=%h want 5a", rdata_a);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    wen = 1'b1; waddr = 20; wdata = 8'hFF;
    tick();
    wen = 1'b0;
    count_busy("sweep_wr_busy", 27);
    raddr_a = 20; raddr_b = 9;
    tick();
    n_cmp++;
    if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
      n_fail++;
      $display("FAIL sweep_write_dropped: a=%h b=%h want 00", rdata_a, rdata_b);
    end
  endtask

  task automatic test_reset_mid_sweep();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i < 17; i++) tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || rdata_a !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_sweep: busy=%b a=%h want 1/00", busy, rdata_a);
    end
    rst = 1'b0;
    tick();
    count_busy("rst_restart_len", 31);
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_fill_read();
    test_bypass();
    test_clear();
    test_write_during_sweep();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
